// File: rtl/scan_counter_pkg.sv
// Shared types, defaults and helpers for the scan counter family
// (display multiplexing, mole-slot selection, mole timer).
package scan_counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;

  localparam int unsigned SCAN_WIDTH    = 32'd2;
  localparam int unsigned SCAN_MODULUS  = 32'd4;
  localparam int unsigned SCAN_PRESCALE = 32'd1;

  // Loaded values at or above the modulus pin to the top count.
  function automatic int unsigned clamp_count(input int unsigned v, input int unsigned modulus);
    if (v >= modulus) begin
      return modulus - 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Enable-gated prescaler: emits a one-cycle tick every PRESCALE enabled clocks.
// Phase is held while en is low; restart re-aligns the phase to zero.
module tick_gen
  import scan_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = SCAN_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);

  if (PRESCALE < 32'd1) begin : g_bad_prescale
    $error("tick_gen: PRESCALE must be at least 1");
  end

  logic [PW-1:0] pre_cnt_r;

  assign tick = en & (pre_cnt_r == LAST);

  // Phase counter: wraps on tick, freezes when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= '0;
    end else if (restart || tick) begin
      pre_cnt_r <= '0;
    end else if (en) begin
      pre_cnt_r <= pre_cnt_r + PW'(1);
    end else begin
      pre_cnt_r <= pre_cnt_r;
    end
  end

endmodule

// File: rtl/scan_counter.sv
// Modulo-MODULUS up/down step counter with prescaler, clear, saturating
// load, step/wrap strobes and a one-hot decode of the registered count.
module scan_counter
  import scan_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = SCAN_WIDTH,
  parameter int unsigned MODULUS  = SCAN_MODULUS,
  parameter int unsigned PRESCALE = SCAN_PRESCALE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               up,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   value,
  output logic               step,
  output logic               wrap,
  output logic [MODULUS-1:0] onehot
);

  if (MODULUS < 32'd2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("scan_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 32'd1);

  logic               tick_s;
  count_dir_e         dir_s;
  logic [WIDTH-1:0]   value_r, value_n;
  logic               step_r, step_n;
  logic               wrap_r, wrap_n;
  logic [MODULUS-1:0] onehot_s;

  assign dir_s = count_dir_e'(up);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (clr | load),
    .tick    (tick_s)
  );

  // Next count: clr beats load beats tick; strobes only on a tick.
  always_comb begin
    value_n = value_r;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
    if (clr) begin
      value_n = '0;
    end else if (load) begin
      value_n = WIDTH'(clamp_count(32'(load_val), MODULUS));
    end else if (tick_s) begin
      step_n = 1'b1;
      case (dir_s)
        DIR_UP: begin
          if (value_r == TOP) begin
            value_n = '0;
            wrap_n  = 1'b1;
          end else begin
            value_n = value_r + WIDTH'(1);
          end
        end
        DIR_DOWN: begin
          if (value_r == '0) begin
            value_n = TOP;
            wrap_n  = 1'b1;
          end else begin
            value_n = value_r - WIDTH'(1);
          end
        end
        default: begin
          value_n = value_r;
        end
      endcase
    end else begin
      value_n = value_r;
    end
  end

  // Count and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= '0;
      step_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      value_r <= value_n;
      step_r  <= step_n;
      wrap_r  <= wrap_n;
    end
  end

  // Decode from the registered count only, so inputs cannot glitch it.
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < int'(MODULUS); i++) begin
      onehot_s[i] = (value_r == WIDTH'(i));
    end
  end

  assign value  = value_r;
  assign step   = step_r;
  assign wrap   = wrap_r;
  assign onehot = onehot_s;

endmodule

// File: tb/tb_scan_counter.sv
// Self-checking bench: three scan_counter configurations against a
// cycle-level arithmetic model (enabled-cycle counting, modular stepping).
module tb_scan_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en, up, clr, load;
  logic [2:0] lv [3];
  logic [1:0] val_a;
  logic [2:0] val_b, val_c;
  logic [2:0] step_o, wrap_o;
  logic [3:0] oh_a;
  logic [4:0] oh_b, oh_c;

  int n_vec = 0;
  int n_mis = 0;
  int mods [3] = '{4, 5, 5};
  int pres [3] = '{1, 3, 4};
  int   m_val  [3];
  int   m_cnt  [3];
  logic m_step [3];
  logic m_wrap [3];

  always #5 clk = ~clk;

  scan_counter #(.WIDTH(2), .MODULUS(4), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .up(up[0]), .clr(clr[0]), .load(load[0]),
    .load_val(lv[0][1:0]), .value(val_a), .step(step_o[0]), .wrap(wrap_o[0]), .onehot(oh_a));
  scan_counter #(.WIDTH(3), .MODULUS(5), .PRESCALE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .up(up[1]), .clr(clr[1]), .load(load[1]),
    .load_val(lv[1]), .value(val_b), .step(step_o[1]), .wrap(wrap_o[1]), .onehot(oh_b));
  scan_counter #(.WIDTH(3), .MODULUS(5), .PRESCALE(4)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .up(up[2]), .clr(clr[2]), .load(load[2]),
    .load_val(lv[2]), .value(val_c), .step(step_o[2]), .wrap(wrap_o[2]), .onehot(oh_c));

  function automatic logic [63:0] obs_pack(input int i);
    case (i)
      0:       return {16'(val_a), step_o[0], wrap_o[0], 14'd0, 32'(oh_a)};
      1:       return {16'(val_b), step_o[1], wrap_o[1], 14'd0, 32'(oh_b)};
      default: return {16'(val_c), step_o[2], wrap_o[2], 14'd0, 32'(oh_c)};
    endcase
  endfunction

  function automatic logic [63:0] exp_pack(input int i);
    logic [31:0] oh_e;
    oh_e = 32'd1 << m_val[i];
    return {16'(m_val[i]), m_step[i], m_wrap[i], 14'd0, oh_e};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_val[i] = 0; m_cnt[i] = 0; m_step[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endtask

  // Model: a step happens on every PRESCALE-th enabled cycle since restart.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int v;
      v = m_val[i];
      m_step[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (clr[i]) begin
        m_val[i] = 0; m_cnt[i] = 0;
      end else if (load[i]) begin
        v = (i == 0) ? int'(lv[i][1:0]) : int'(lv[i]);
        m_val[i] = (v >= mods[i]) ? mods[i] - 1 : v;
        m_cnt[i] = 0;
      end else if (en[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] % pres[i] == 0) begin
          m_step[i] = 1'b1;
          m_val[i]  = up[i] ? (v + 1) % mods[i] : (v + mods[i] - 1) % mods[i];
          m_wrap[i] = up[i] ? (m_val[i] < v) : (m_val[i] > v);
        end
      end
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 3'b000; up = 3'b000; clr = 3'b000; load = 3'b000;
    for (int i = 0; i < 3; i++) lv[i] = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (obs_pack(i) !== exp_pack(i)) begin
        n_mis++;
        $display("FAIL reset inst%0d: got %h want %h", i, obs_pack(i), exp_pack(i));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    clr[0] = 1'b1; advance(); clr[0] = 1'b0;
    en[0] = 1'b1; up[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      advance();
      n_vec++;
      if (obs_pack(0) !== exp_pack(0)) begin
        n_mis++;
        $display("FAIL up_wrap cyc%0d: got %h want %h", k, obs_pack(0), exp_pack(0));
      end
      n_vec++;
      if ({30'd0, val_a} !== 32'((k + 1) % 4) || wrap_o[0] !== ((k + 1) % 4 == 0)) begin
        n_mis++;
        $display("FAIL up_wrap_seq cyc%0d: got value %0d wrap %b want %0d", k, val_a, wrap_o[0], (k + 1) % 4);
      end
    end
    en[0] = 1'b0;
  endtask

  task automatic test_down_prescale();
    clr[1] = 1'b1; advance(); clr[1] = 1'b0;
    en[1] = 1'b1; up[1] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      advance();
      n_vec++;
      if (obs_pack(1) !== exp_pack(1)) begin
        n_mis++;
        $display("FAIL down_prescale cyc%0d: got %h want %h", k, obs_pack(1), exp_pack(1));
      end
    end
    en[1] = 1'b0;
  endtask

  task automatic test_en_freeze();
    int first;
    first = 0;
    clr[2] = 1'b1; advance(); clr[2] = 1'b0;
    up[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      en[2] = (k < 2);
      advance();
      n_vec++;
      if (obs_pack(2) !== exp_pack(2)) begin
        n_mis++;
        $display("FAIL en_freeze hold cyc%0d: got %h want %h", k, obs_pack(2), exp_pack(2));
      end
    end
    en[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      advance();
      if (step_o[2] === 1'b1 && first == 0) first = k;
      n_vec++;
      if (obs_pack(2) !== exp_pack(2)) begin
        n_mis++;
        $display("FAIL en_freeze resume cyc%0d: got %h want %h", k, obs_pack(2), exp_pack(2));
      end
    end
    n_vec++;
    if (first != 2) begin
      n_mis++;
      $display("FAIL en_freeze_phase: first step after %0d cycles, want 2", first);
    end
    en[2] = 1'b0;
  endtask

  task automatic test_load_sat();
    load[1] = 1'b1; lv[1] = 3'd7;
    advance();
    n_vec++;
    if (val_b !== 3'd4 || obs_pack(1) !== exp_pack(1)) begin
      n_mis++;
      $display("FAIL load_sat: got %h want value 4 / %h", obs_pack(1), exp_pack(1));
    end
    clr[1] = 1'b1; load[1] = 1'b1; lv[1] = 3'd2; en[1] = 1'b1;
    advance();
    n_vec++;
    if ({val_b, step_o[1], wrap_o[1]} !== 5'b000_0_0 || obs_pack(1) !== exp_pack(1)) begin
      n_mis++;
      $display("FAIL clr_over_load: got %h want %h", obs_pack(1), exp_pack(1));
    end
    clr[1] = 1'b0; load[1] = 1'b0; en[1] = 1'b0;
  endtask

  task automatic test_dir_flip();
    int flip_seq [3] = '{1, 0, 3};
    clr[0] = 1'b1; advance(); clr[0] = 1'b0;
    en[0] = 1'b1; up[0] = 1'b1;
    advance(); advance();
    up[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      advance();
      n_vec++;
      if ({30'd0, val_a} !== 32'(flip_seq[k]) || obs_pack(0) !== exp_pack(0)) begin
        n_mis++;
        $display("FAIL dir_flip cyc%0d: got value %0d want %0d", k, val_a, flip_seq[k]);
      end
    end
    en[0] = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 3; i++) begin
        en[i]   = ($urandom_range(0, 3) != 0);
        up[i]   = $urandom_range(0, 1) == 1;
        clr[i]  = ($urandom_range(0, 31) == 0);
        load[i] = ($urandom_range(0, 23) == 0);
        lv[i]   = 3'($urandom_range(0, 7));
      end
      advance();
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (obs_pack(i) !== exp_pack(i)) begin
          n_mis++;
          $display("FAIL random cyc%0d inst%0d: got %h want %h", k, i, obs_pack(i), exp_pack(i));
        end
      end
    end
    en = 3'b000; clr = 3'b000; load = 3'b000;
  endtask

  task automatic test_async_reset();
    int first;
    first = 0;
    clr[2] = 1'b1; advance(); clr[2] = 1'b0;
    en[2] = 1'b1; up[2] = 1'b1;
    for (int k = 0; k < 40 && !(m_val[2] == 3 && m_cnt[2] % 4 == 2); k++) advance();
    n_vec++;
    if (!(m_val[2] == 3 && m_cnt[2] % 4 == 2) || obs_pack(2) !== exp_pack(2)) begin
      n_mis++;
      $display("FAIL async_pre: got %h want %h", obs_pack(2), exp_pack(2));
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (obs_pack(i) !== exp_pack(i)) begin
        n_mis++;
        $display("FAIL async_clear inst%0d: got %h want %h", i, obs_pack(i), exp_pack(i));
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      advance();
      if (step_o[2] === 1'b1 && first == 0) first = k;
      n_vec++;
      if (obs_pack(2) !== exp_pack(2)) begin
        n_mis++;
        $display("FAIL async_resume cyc%0d: got %h want %h", k, obs_pack(2), exp_pack(2));
      end
    end
    n_vec++;
    if (first != 4) begin
      n_mis++;
      $display("FAIL async_first_step: after %0d cycles, want 4", first);
    end
    en[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_prescale();
    test_en_freeze();
    test_load_sat();
    test_dir_flip();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/scan_counter.md
# scan_counter

Parametrised modulo-N step counter that replaces the fixed free-running 2-bit counter used for display and mole-slot scanning. It adds a clock prescaler, enable, count direction, synchronous clear, parallel load, wrap/step strobes and a one-hot decode of the count. It sits between the system clock and the display multiplexer and game-slot selection logic. One instance per scan domain.

## Interface
- WIDTH, 2, counter width in bits; 1..16
- MODULUS, 4, count range 0..MODULUS-1; 2..2**WIDTH
- PRESCALE, 1, enabled clocks per count step; 1..2**20; 1 means every enabled clock
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  count enable; gates both prescaler and counter
- up  in  1  direction; 1 = increment, 0 = decrement
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- value  out  WIDTH  current count, registered
- step  out  1  one-cycle strobe: value changed by a count step this cycle
- wrap  out  1  one-cycle strobe: the step crossed the modulus boundary
- onehot  out  MODULUS  onehot[i] = (value == i), decoded from registered value

## Operation
- Internal prescaler pre_cnt runs 0..PRESCALE-1 and advances only when en=1. tick = en & (pre_cnt == PRESCALE-1). pre_cnt returns to 0 on tick.
- Priority per edge: clr > load > tick > hold.
- clr=1: value<=0, pre_cnt<=0, step<=0, wrap<=0. Ignores en.
- load=1 (clr=0): value<=load_val, saturated to MODULUS-1 if load_val >= MODULUS. pre_cnt<=0, step<=0, wrap<=0. Ignores en.
- tick, up=1: value==MODULUS-1 -> 0 with wrap<=1; otherwise value+1. step<=1.
- tick, up=0: value==0 -> MODULUS-1 with wrap<=1; otherwise value-1. step<=1.
- No tick: value and pre_cnt hold (pre_cnt advances if en); step<=0, wrap<=0.
- en=0 freezes the phase. The prescaler resumes from its held pre_cnt, not from 0.
- A change of up takes effect on the next tick. No restart and no extra cycle.
- Arithmetic is done in WIDTH bits. The counter never holds a value >= MODULUS, including after reset and load.

## Timing
- Reset, asynchronous on rst_n low: value=0, pre_cnt=0, step=0, wrap=0, onehot=1 (bit 0). Release is synchronous to the next rising clk.
- Latency: clr, load and tick all act on the next rising edge. step and wrap are high in the same cycle the new value appears, for exactly one cycle.
- With en held high, the step period is PRESCALE cycles and the wrap period is MODULUS*PRESCALE cycles.
- With PRESCALE=1 and en=1, value changes every cycle and step is held high continuously.
- If rst_n is asserted mid-count, all state clears immediately with no pending strobe. The first tick after release occurs PRESCALE enabled cycles later.
- onehot is combinational from value only and has no glitch path from inputs.

## Structure
- Package scan_counter_pkg holds:
  - typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} count_dir_e
  - localparam defaults for WIDTH, MODULUS and PRESCALE, used by the display and game tops
- Sub-module tick_gen(PRESCALE) contains pre_cnt and the tick output, with en, clr/load-restart and rst_n inputs. It is reused by the mole timer.
- Parameter legality (MODULUS <= 2**WIDTH, PRESCALE >= 1) is checked at elaboration with $error.
- pre_cnt width is $clog2(PRESCALE), minimum 1.

## Test plan
- Reset/default (WIDTH=2, MODULUS=4, PRESCALE=1), en=1, up=1 for 9 cycles -> value 1,2,3,0,1,2,3,0,1; wrap on the cycles showing 0; onehot matches value throughout.
- MODULUS=5, WIDTH=3, PRESCALE=3, up=0, en=1 -> value steps 0->4->3->2->1->0 every 3 cycles; wrap only on 0->4; step high 1 cycle in every 3.
- PRESCALE=4: en=1 for 2 cycles, en=0 for 5, then en=1 -> first step after 2 more enabled cycles (phase held); value unchanged while en=0.
- MODULUS=5, load_val=7 with load=1 -> value=4. Next: clr=1 and load=1 together -> value=0, no step or wrap.
- Flip up from 1 to 0 at value=2 on PRESCALE=1 -> next values 1,0,MODULUS-1; no skipped or duplicated count.
- Drop rst_n mid-count at value=3, pre_cnt=2 -> outputs clear asynchronously, before the next edge; after release the first step occurs exactly PRESCALE cycles later.
